// File: rtl/uart_transmitter.sv
// UART serial transmitter: one-byte holding buffer feeding a shift register, LSB first, optional parity, 1 or 2 stop bits.
// Latency: write sampled at edge N drives the start bit after edge N+1; writes while the buffer is full are dropped.
module uart_transmitter #(
    parameter int DATA_BITS = 8,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clock_50MHz,
    input  logic                 reset_n,
    input  logic [7:0]           txData,
    input  logic                 txDataWrite,
    input  logic                 txEnable,
    input  logic [DIV_WIDTH-1:0] baudDivisor,
    input  logic                 parityEnable,
    input  logic                 parityOdd,
    input  logic                 twoStopBits,
    input  logic                 txcClear,
    output logic                 txd,
    output logic                 udre,
    output logic                 txc,
    output logic                 busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP1  = 3'd4;
    localparam logic [2:0] S_STOP2  = 3'd5;

    logic [2:0]           state;
    logic [DIV_WIDTH-1:0] baud_cnt;
    logic [7:0]           hold_buf;
    logic [7:0]           shift;
    logic [3:0]           bit_cnt;
    logic                 par_bit;

    logic                 tick;
    logic                 frame_end;
    logic                 load;
    logic [7:0]           data_mask;
    logic                 buf_parity;

    always_comb begin
        data_mask = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < DATA_BITS) data_mask[i] = 1'b1;
        end
        tick       = (baud_cnt == baudDivisor);
        frame_end  = tick && ((state == S_STOP1 && !twoStopBits) || state == S_STOP2);
        load       = txEnable && !udre && (state == S_IDLE || frame_end);
        buf_parity = (^(hold_buf & data_mask)) ^ parityOdd;
    end

    assign busy = (state != S_IDLE);

    // A load frees the buffer on the same edge, so a coincident write is still accepted.
    always_ff @(posedge clock_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            udre     <= 1'b1;
            hold_buf <= '0;
        end else if (txDataWrite && (udre || load)) begin
            hold_buf <= txData;
            udre     <= 1'b0;
        end else if (load) begin
            udre <= 1'b1;
        end
    end

    always_ff @(posedge clock_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            shift    <= '0;
            bit_cnt  <= '0;
            par_bit  <= 1'b0;
            txd      <= 1'b1;
            txc      <= 1'b0;
        end else begin
            if (txcClear) txc <= 1'b0;

            if (load) begin
                shift    <= hold_buf;
                par_bit  <= buf_parity;
                bit_cnt  <= '0;
                baud_cnt <= '0;
                state    <= S_START;
                txd      <= 1'b0;
            end else if (state == S_IDLE) begin
                baud_cnt <= '0;
                txd      <= 1'b1;
            end else if (!tick) begin
                baud_cnt <= baud_cnt + 1'b1;
            end else begin
                baud_cnt <= '0;
                case (state)
                    S_START: begin
                        state <= S_DATA;
                        txd   <= shift[0];
                    end
                    S_DATA: begin
                        if (bit_cnt == 4'(DATA_BITS - 1)) begin
                            if (parityEnable) begin
                                state <= S_PARITY;
                                txd   <= par_bit;
                            end else begin
                                state <= S_STOP1;
                                txd   <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            shift   <= {1'b0, shift[7:1]};
                            txd     <= shift[1];
                        end
                    end
                    S_PARITY: begin
                        state <= S_STOP1;
                        txd   <= 1'b1;
                    end
                    S_STOP1: begin
                        txd <= 1'b1;
                        if (twoStopBits) begin
                            state <= S_STOP2;
                        end else begin
                            state <= S_IDLE;
                            txc   <= 1'b1;
                        end
                    end
                    S_STOP2: begin
                        txd   <= 1'b1;
                        state <= S_IDLE;
                        txc   <= 1'b1;
                    end
                    default: begin
                        state <= S_IDLE;
                        txd   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed and randomized frames compared against a per-bit frame model built from byte and line settings.
`timescale 1ns/1ps
module tb_uart_transmitter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  tx_data = '0;
    logic        wr = 1'b0;
    logic        en = 1'b0;
    logic [15:0] div = '0;
    logic        pe = 1'b0;
    logic        po = 1'b0;
    logic        tsb = 1'b0;
    logic        clr = 1'b0;
    logic        txd, udre, txc, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_transmitter #(.DATA_BITS(8), .DIV_WIDTH(16)) dut (
        .clock_50MHz (clk),
        .reset_n     (rst_n),
        .txData      (tx_data),
        .txDataWrite (wr),
        .txEnable    (en),
        .baudDivisor (div),
        .parityEnable(pe),
        .parityOdd   (po),
        .twoStopBits (tsb),
        .txcClear    (clr),
        .txd         (txd),
        .udre        (udre),
        .txc         (txc),
        .busy        (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line level of bit slot i of a frame: start, 8 data LSB first, optional parity, stop(s).
    function automatic logic exp_bit(input logic [7:0] b, input int i, input logic p_en, input logic p_odd);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (i == 9 && p_en) return (^b) ^ p_odd;
        return 1'b1;
    endfunction

    function automatic int frame_bits(input logic p_en, input logic two);
        return 10 + int'(p_en) + int'(two);
    endfunction

    // Called on the first start-bit sample; ends on the first sample after the frame.
    task automatic check_bits(input logic [7:0] b, input bit clr_end);
        int nb;
        int per;
        nb  = frame_bits(pe, tsb);
        per = int'(div) + 1;
        chk("txc_low_at_start", txc, 0);
        for (int i = 0; i < nb; i++) begin
            for (int k = 0; k < per; k++) begin
                chk($sformatf("txd_b%02h_bit%0d", b, i), txd, exp_bit(b, i, pe, po));
                if (i == nb - 1 && k == per - 1) begin
                    chk("busy_last_clock", busy, 1);
                    clr = clr_end;
                end
                step();
                wr = 1'b0;
            end
        end
        clr = 1'b0;
        chk("txd_idle_after", txd, 1);
        chk("busy_after", busy, 0);
        chk("txc_after", txc, 1);
    endtask

    task automatic run_frame(input logic [7:0] b, input bit clr_end);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("txc_cleared", txc, 0);
        tx_data = b;
        wr = 1'b1;
        step();
        wr = 1'b0;
        chk("udre_after_write", udre, 0);
        chk("txd_before_load", txd, 1);
        step();
        chk("txd_start_latency", txd, 0);
        chk("udre_after_load", udre, 1);
        chk("busy_after_load", busy, 1);
        check_bits(b, clr_end);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int per;
        int len;
        logic exp_txd;
        en = 1'b1;
        div = 16'd3;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_txd", txd, 1);
        chk("rst_udre", udre, 1);
        chk("rst_txc", txc, 0);
        chk("rst_busy", busy, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("idle_txd", txd, 1);
        chk("idle_busy", busy, 0);

        pe = 1'b0; po = 1'b0; tsb = 1'b0;
        run_frame(8'h55, 1'b0);
        pe = 1'b1;
        run_frame(8'hA5, 1'b0);
        po = 1'b1;
        run_frame(8'hA5, 1'b0);
        tsb = 1'b1;
        run_frame(8'hA5, 1'b0);

        for (int r = 0; r < 6; r++) begin
            div = 16'($urandom_range(0, 3));
            pe  = 1'($urandom_range(0, 1));
            po  = 1'($urandom_range(0, 1));
            tsb = 1'($urandom_range(0, 1));
            run_frame(8'($urandom_range(0, 255)), 1'b0);
        end

        // Back-to-back frames plus a dropped third write.
        div = 16'd1; pe = 1'b0; po = 1'b0; tsb = 1'b0;
        clr = 1'b1; step(); clr = 1'b0;
        tx_data = 8'h11; wr = 1'b1; step(); wr = 1'b0; step();
        per = int'(div) + 1;
        len = frame_bits(pe, tsb) * per;
        for (int j = 0; j < 2 * len + 4; j++) begin
            if (j == 0) begin
                chk("b2b_udre_free", udre, 1);
                tx_data = 8'h22; wr = 1'b1;
            end
            if (j == 1) begin
                chk("b2b_udre_full", udre, 0);
                tx_data = 8'h33; wr = 1'b1;
            end
            if (j == 2) wr = 1'b0;
            if (j < len)          exp_txd = exp_bit(8'h11, j / per, pe, po);
            else if (j < 2 * len) exp_txd = exp_bit(8'h22, (j - len) / per, pe, po);
            else                  exp_txd = 1'b1;
            chk($sformatf("b2b_txd_%0d", j), txd, exp_txd);
            chk($sformatf("b2b_txc_%0d", j), txc, (j >= 2 * len) ? 1 : 0);
            chk($sformatf("b2b_busy_%0d", j), busy, (j < 2 * len) ? 1 : 0);
            step();
        end
        chk("b2b_third_dropped", udre, 1);

        // Clear coincident with set, then a lone clear.
        div = 16'd0;
        run_frame(8'h96, 1'b1);
        clr = 1'b1; step(); clr = 1'b0;
        chk("lone_clear", txc, 0);

        // Enable dropped during a frame with a byte buffered.
        div = 16'd1; pe = 1'b1; po = 1'b0; tsb = 1'b0;
        tx_data = 8'h3C; wr = 1'b1; step(); wr = 1'b0; step();
        tx_data = 8'hC3; wr = 1'b1; en = 1'b0;
        check_bits(8'h3C, 1'b0);
        chk("en_udre_held", udre, 0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("en_idle_txd", txd, 1);
            chk("en_idle_busy", busy, 0);
        end
        chk("en_udre_still_held", udre, 0);
        clr = 1'b1; step(); clr = 1'b0;
        en = 1'b1;
        step();
        chk("en_resume_start", txd, 0);
        chk("en_resume_udre", udre, 1);
        check_bits(8'hC3, 1'b0);

        // Reset in the middle of a data bit.
        div = 16'd0; pe = 1'b0; tsb = 1'b0;
        tx_data = 8'h00; wr = 1'b1; step(); wr = 1'b0;
        step(); step(); step(); step();
        chk("pre_reset_txd", txd, 0);
        chk("pre_reset_txc", txc, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_txd", txd, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_udre", udre, 1);
        chk("mid_rst_txc", txc, 0);
        step();
        rst_n = 1'b1;
        step();
        run_frame(8'($urandom_range(0, 255)), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
Serial transmit engine of the software-defined UART. Consumes data-register writes and control/status fields from the UART register file, serialises frames onto txd (LSB first), and returns UDRE/TXC/busy status flags to the register file. Single-entry holding buffer plus shift register, so software can queue one byte while another is on the wire.

Parameters:
DATA_BITS, 8, data bits per frame (5..8 supported; upper buffer bits ignored)
DIV_WIDTH, 16, width of baud divisor field

Ports:
clock_50MHz  input  1  system clock
reset_n  input  1  asynchronous active-low reset
txData  input  8  byte to send (register file UDR write data)
txDataWrite  input  1  one-cycle strobe: capture txData into holding buffer
txEnable  input  1  transmitter enable (UCSRB TXEN)
baudDivisor  input  DIV_WIDTH  bit period = baudDivisor+1 clocks
parityEnable  input  1  insert parity bit after data
parityOdd  input  1  1 = odd parity, 0 = even
twoStopBits  input  1  1 = two stop bits
txcClear  input  1  one-cycle strobe: clear txc
txd  output  1  serial line, idle high, registered
udre  output  1  holding buffer empty
txc  output  1  sticky transmit-complete flag
busy  output  1  frame in progress (state != IDLE)

Behaviour:
- Reset (async, reset_n low): txd=1, udre=1, txc=0, busy=0, state IDLE, baud counter 0, buffer contents don't-care. Reset mid-frame aborts the frame immediately; txd returns high in the same reset assertion.
- Holding buffer: txDataWrite with udre=1 captures txData at that edge, udre<=0. txDataWrite with udre=0 is ignored (buffer unchanged, no overwrite).
- Load: in IDLE with udre=0 and txEnable=1, the next edge copies buffer to shift register, udre<=1, state<=START, txd<=0, baud counter<=0. Latency: write sampled at edge N -> txd low after edge N+1.
- Write on the same edge as a load: the load takes the old byte; the new byte is captured; udre stays 0.
- Baud timing: counter increments each clock; tick when counter==baudDivisor, then counter<=0. Each bit lasts exactly baudDivisor+1 clocks. baudDivisor=0 yields 1 clock/bit. baudDivisor is sampled live; software changes it only while busy=0.
- FSM: IDLE -> START -> DATA (DATA_BITS ticks, LSB first, shift right) -> PARITY (if parityEnable) -> STOP1 -> STOP2 (if twoStopBits) -> IDLE, or directly to START if the buffer is full and txEnable=1 (back-to-back, no idle gap).
- Parity: XOR of the DATA_BITS data bits, inverted when parityOdd=1.
- txd is driven from registered state: START=0, DATA=shift[0], PARITY=p, STOP/IDLE=1.
- txc: set on the final stop-bit tick when the frame returns to IDLE (buffer empty or txEnable=0). Cleared by txcClear. If set and clear occur on the same cycle, set wins. Not set between back-to-back frames.
- txEnable deasserted mid-frame: the current frame completes normally. No new load occurs; buffered data is retained until re-enabled.
- Frame length in clocks = (baudDivisor+1) x (1 + DATA_BITS + parityEnable + 1 + twoStopBits).

Test Plan:
- Reset, then baudDivisor=3, no parity, 1 stop, write 0x55 -> txd low 1 clock after write edge; bit sequence 0,1,0,1,0,1,0,1,0,1 each 4 clocks; 40 clocks total; txc=1 at end; udre=1 one clock after write+1.
- parityEnable=1, parityOdd=0, write 0xA5 -> parity bit 0; repeat with parityOdd=1 -> parity bit 1; twoStopBits=1 -> frame 12 bits = 48 clocks at divisor 3.
- Write 0x11 then 0x22 as soon as udre=1, then 0x33 while udre=0 -> 0x11 and 0x22 sent back-to-back with no gap; 0x33 dropped; txc set once, only after the 0x22 stop bit.
- txcClear pulse coincident with the txc-set cycle -> txc=1; later lone txcClear -> txc=0.
- Drop txEnable mid-frame with a byte buffered -> current frame completes; txd idles high; udre stays 0; re-assert -> buffered byte sent.
- Assert reset_n low mid-data-bit at divisor 0 -> txd=1, busy=0, udre=1, txc=0 asynchronously; a fresh write after release sends a correct frame.
